cen_generator_multi: RTL and testbench
======================================

// Module: cen_generator_multi
// PURPOSE
//  N-channel clock-enable generator with a parametrised counter width. Each channel has its own
//  prescaler, phase offset, enable and mode (continuous or one-shot). A global sync input
//  re-aligns all channels. It drives the sample-rate strobes for the filtering datapath
//  (ADC strobe, filter CEN, decimator CEN), with each channel phase-shifted against the others.
// PARAMETERS
//  N_CH   4   number of independent channels (1..16)
//  CNT_W  32  prescaler/phase/counter width in bits (8..32)
// PORTS
//  clk          in   1         system clock
//  rstn         in   1         reset, synchronous, active-low
//  i_enable     in   N_CH      per-channel enable; 0 = channel held idle
//  i_mode       in   N_CH      per-channel mode: 0 = continuous, 1 = one-shot
//  i_prescaler  in   N_CH*CNT_W  per-channel period-1; channel k at [k*CNT_W +: CNT_W]
//  i_phase      in   N_CH*CNT_W  per-channel counter load value at start/sync
//  i_trigger    in   N_CH      one-shot start pulse (ignored in continuous mode)
//  i_sync       in   1         global re-align pulse for all running continuous channels
//  o_cen        out  N_CH      registered one-cycle clock-enable pulses
//  o_busy       out  N_CH      1 while channel counting (RUN or SHOT state)
// BEHAVIOUR
//  - Reset: all counters 0, o_cen = 0, o_busy = 0, all channels in IDLE.
//  - Per-channel FSM with states IDLE, RUN and SHOT. The counter C is CNT_W bits, unsigned.
//  - IDLE: C=0, o_cen=0. If enable=1 & mode=0 -> RUN, C<=phase_sat.
//    If enable=1 & mode=1 & trigger=1 -> SHOT, C<=phase_sat.
//  - phase_sat = min(phase, prescaler). A phase above the prescaler therefore fires on the next cycle.
//  - RUN: if C>=P then C<=0 and o_cen<=1 (next cycle), else C<=C+1 and o_cen<=0.
//    Period = P+1 cycles. P=0 gives o_cen high every cycle.
//  - SHOT: same compare. On C>=P: o_cen<=1 for exactly one cycle, state<=IDLE, busy<=0.
//    A trigger received while in SHOT is ignored (no restart).
//  - Compare is against the live prescaler. If P is lowered below C, the compare fires on the
//    next cycle and no wrap to 2^CNT_W occurs. The counter never exceeds max(P_old,P_new).
//  - i_enable=0 in any state: IDLE on the next cycle, C=0, o_cen=0. This aborts a pending shot
//    with no pulse.
//  - Mode change while in RUN or SHOT takes effect only after the channel returns to IDLE.
//  - i_sync=1: every channel in RUN loads C<=phase_sat and o_cen<=0 that cycle.
//    Sync has priority over the compare. IDLE and SHOT channels are unaffected.
//  - Simultaneous enable rise and sync: the channel enters RUN with C=phase_sat (identical result).
//  - Latency: enable/trigger at cycle t -> state change at t+1. With phase=P,
//    first o_cen is at t+2.
//  - o_busy = (state != IDLE), registered with the state.
//  - No arithmetic overflow: C+1 is evaluated only when C<P<=2^CNT_W-1.
// STRUCTURE
//  - Package cen_pkg holds:
//    - localparams MODE_CONT=1'b0 and MODE_SHOT=1'b1
//    - state encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_SHOT=2'd2
//  - Sub-module cen_channel (one channel: FSM + counter, parameter CNT_W).
//  - The top level instantiates it N_CH times in a generate loop, slicing the packed buses.
//  - Top level has no logic beyond slicing and fan-out of i_sync.
// TESTING
//  1 N_CH=4,CNT_W=8. ch0 P=4,phase=0,cont. Enable at cycle 10 -> o_cen[0] at cycles 16,21,26...
//    (period 5).
//  2 P=0 on ch1, cont -> o_cen[1] high every cycle from 2 cycles after enable.
//    Deassert enable -> low the next cycle.
//  3 ch0..3 P=3, phases 0,1,2,3. Pulse i_sync -> o_cen pulses staggered one cycle apart
//    (ch3 first, ch0 last), period 4.
//  4 ch2 one-shot, P=5, phase=0. Trigger -> single o_cen[2] 7 cycles later, o_busy[2] high
//    6 cycles. A second trigger mid-count produces no extra pulse.
//  5 ch0 running P=200 with C≈150. Write P=10 -> o_cen on the next cycle, then period 11.
//    Also phase=250>P=10 -> fires first cycle.
//  6 Assert rstn=0 mid-count and mid-shot -> next cycle all o_cen=0, o_busy=0.
//    After release, channels restart from IDLE.

Source files
------------

// File: rtl/cen_pkg.sv
// Shared constants for the multi-channel clock-enable generator.
package cen_pkg;

    localparam logic MODE_CONT = 1'b0;
    localparam logic MODE_SHOT = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SHOT = 2'd2;

endpackage

// File: rtl/cen_channel.sv
// One clock-enable channel: IDLE/RUN/SHOT state machine with a prescaler counter.
module cen_channel
    import cen_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             mode,
    input  logic             trigger,
    input  logic             sync,
    input  logic [CNT_W-1:0] prescaler,
    input  logic [CNT_W-1:0] phase,
    output logic             cen,
    output logic             busy
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_sat;
    logic             at_top;

    // A phase beyond the period is clamped so the channel fires on its first counting cycle.
    assign phase_sat = (phase > prescaler) ? prescaler : phase;
    // Compare against the live prescaler: lowering it below cnt fires at once, never wraps.
    assign at_top    = (cnt >= prescaler);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cen   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cen <= 1'b0;
                    if (mode == MODE_CONT) begin
                        state <= ST_RUN;
                        cnt   <= phase_sat;
                    end else if (trigger) begin
                        state <= ST_SHOT;
                        cnt   <= phase_sat;
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (sync) begin
                        cnt <= phase_sat;
                        cen <= 1'b0;
                    end else if (at_top) begin
                        cnt <= '0;
                        cen <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        cen <= 1'b0;
                    end
                end
                ST_SHOT: begin
                    if (at_top) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        cen   <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        cen   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    cen   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cen_generator_multi.sv
// N-channel clock-enable generator: one cen_channel per channel, shared sync.
module cen_generator_multi
    import cen_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_CH-1:0]       i_enable,
    input  logic [N_CH-1:0]       i_mode,
    input  logic [N_CH*CNT_W-1:0] i_prescaler,
    input  logic [N_CH*CNT_W-1:0] i_phase,
    input  logic [N_CH-1:0]       i_trigger,
    input  logic                  i_sync,
    output logic [N_CH-1:0]       o_cen,
    output logic [N_CH-1:0]       o_busy
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cen_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .enable   (i_enable[g]),
            .mode     (i_mode[g]),
            .trigger  (i_trigger[g]),
            .sync     (i_sync),
            .prescaler(i_prescaler[g*CNT_W +: CNT_W]),
            .phase    (i_phase[g*CNT_W +: CNT_W]),
            .cen      (o_cen[g]),
            .busy     (o_busy[g])
        );
    end

endmodule

// File: tb/tb_cen_generator_multi.sv
// Self-checking bench for cen_generator_multi (N_CH=4, CNT_W=8).
module tb_cen_generator_multi;

    localparam int N  = 4;
    localparam int W  = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   en, mode, trig, cen, busy;
    logic           sync;
    logic [N*W-1:0] pres, phs;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel activity (0 idle, 1 running, 2 one-shot), count, pulse.
    int m_act [N];
    int m_cnt [N];
    bit m_cen [N];

    cen_generator_multi #(.N_CH(N), .CNT_W(W)) dut (
        .clk(clk), .rstn(rstn), .i_enable(en), .i_mode(mode),
        .i_prescaler(pres), .i_phase(phs), .i_trigger(trig), .i_sync(sync),
        .o_cen(cen), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] en, mode, trig;
        logic         sync;
        logic [N-1:0] exp_cen, exp_busy;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_step();
        int p, ph;
        for (int k = 0; k < N; k++) begin
            p  = int'(pres[k*W +: W]);
            ph = int'(phs[k*W +: W]);
            if (ph > p) ph = p;
            if (!rstn || !en[k]) begin
                m_act[k] = 0; m_cnt[k] = 0; m_cen[k] = 0;
            end else if (m_act[k] == 0) begin
                m_cen[k] = 0;
                if (!mode[k])     begin m_act[k] = 1; m_cnt[k] = ph; end
                else if (trig[k]) begin m_act[k] = 2; m_cnt[k] = ph; end
                else m_cnt[k] = 0;
            end else if (m_act[k] == 1 && sync) begin
                m_cnt[k] = ph; m_cen[k] = 0;
            end else if (m_cnt[k] >= p) begin
                m_cnt[k] = 0; m_cen[k] = 1;
                if (m_act[k] == 2) m_act[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1; m_cen[k] = 0;
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int k, input int p, input int ph);
        pres[k*W +: W] = W'(p);
        phs[k*W +: W]  = W'(ph);
    endtask

    task automatic do_reset();
        rstn = 1'b0; en = '0; mode = '0; trig = '0; sync = 1'b0;
        pres = '0; phs = '0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    vec_t tbl [15];
    logic [N-1:0] ecen, ebusy;

    initial begin
        // Ch1 continuous P=0, then ch2 one-shot P=5 with ignored retrigger and an abort.
        tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010};
        tbl[1]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        tbl[2]  = '{4'b0010, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100};
        tbl[5]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100};
        tbl[6]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0100};
        tbl[7]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100};
        tbl[9]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100};
        tbl[10] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000};
        tbl[11] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100};
        tbl[13] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000};

        do_reset();
        check("reset_cen", 32'(cen), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Table-driven vectors
        set_cfg(1, 0, 0);
        set_cfg(2, 5, 0);
        for (int i = 0; i < 15; i++) begin
            en = tbl[i].en; mode = tbl[i].mode; trig = tbl[i].trig; sync = tbl[i].sync;
            tick();
            check($sformatf("tbl%0d_cen", i), 32'(cen), 32'(tbl[i].exp_cen));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        end

        // Continuous ch0, P=4: pulses 6,11,16 cycles after the enable cycle
        do_reset();
        set_cfg(0, 4, 0);
        en = 4'b0001;
        for (int j = 1; j <= 16; j++) begin
            tick();
            check($sformatf("period5_j%0d", j), 32'(cen[0]),
                  32'((j >= 6 && (j - 6) % 5 == 0) ? 1 : 0));
        end

        // Staggered phases re-aligned by sync
        do_reset();
        for (int k = 0; k < N; k++) set_cfg(k, 3, k);
        en = 4'b1111;
        repeat (7) tick();
        sync = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            sync = 1'b0;
            ecen = '0;
            for (int k = 0; k < N; k++)
                ecen[k] = (j >= 5 - k) && ((j - 5 + k) % 4 == 0);
            check($sformatf("sync_j%0d", j), 32'(cen), 32'(ecen));
        end

        // Prescaler lowered below a large count fires at once, then period 11
        do_reset();
        set_cfg(0, 200, 0);
        en = 4'b0001;
        repeat (151) tick();
        set_cfg(0, 10, 0);
        for (int j = 1; j <= 23; j++) begin
            tick();
            check($sformatf("lowerP_j%0d", j), 32'(cen[0]),
                  32'((j == 1 || j == 12 || j == 23) ? 1 : 0));
        end
        en = '0;
        tick();
        set_cfg(0, 10, 250);
        en = 4'b0001;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check($sformatf("phsat_j%0d", j), 32'(cen[0]), 32'((j == 2) ? 1 : 0));
        end

        // Reset mid-count and mid-shot
        do_reset();
        set_cfg(0, 5, 0);
        set_cfg(2, 5, 0);
        en = 4'b0101; mode = 4'b0100; trig = 4'b0100;
        tick();
        trig = '0;
        repeat (3) tick();
        check("pre_rst_busy", 32'(busy), 32'h5);
        rstn = 1'b0;
        tick();
        check("rst_mid_cen", 32'(cen), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'h1);
        check("post_rst_cen", 32'(cen), 32'h0);

        // Randomized run against the reference model
        do_reset();
        for (int k = 0; k < N; k++) set_cfg(k, $urandom_range(7), $urandom_range(9));
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(15) == 0) set_cfg(k, $urandom_range(7), $urandom_range(9));
                if ($urandom_range(19) == 0) begin
                    en[k]   = ~en[k];
                    mode[k] = 1'($urandom_range(1));
                end
                trig[k] = ($urandom_range(5) == 0);
            end
            sync = ($urandom_range(24) == 0);
            rstn = ($urandom_range(199) != 0);
            tick();
            ecen = '0; ebusy = '0;
            for (int k = 0; k < N; k++) begin
                ecen[k]  = m_cen[k];
                ebusy[k] = (m_act[k] != 0);
            end
            check($sformatf("rnd%0d_cen", c), 32'(cen), 32'(ecen));
            check($sformatf("rnd%0d_busy", c), 32'(busy), 32'(ebusy));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
